// File: rtl/ntlm_cand_enum.sv
// ntlm_cand_enum: walks charset^0..charset^MAX_LEN in odometer order and streams each
// candidate as a padded UTF-16LE MD4 block over a valid/ready interface.
// Optional feature macro: NTCAND_RESUME_EN adds resume_load/resume_pw/resume_len so
// enumeration can restart from an arbitrary password instead of the empty one.
module ntlm_cand_enum #(
    parameter int unsigned MAX_LEN  = 20,
    parameter logic [7:0]  MIN_CHAR = 8'h20,
    parameter logic [7:0]  MAX_CHAR = 8'h7E,
    parameter int unsigned COUNT_W  = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
`ifdef NTCAND_RESUME_EN
    input  logic                 resume_load,
    input  logic [8*MAX_LEN-1:0] resume_pw,
    input  logic [4:0]           resume_len,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [511:0]         md4_block,
    output logic [8*MAX_LEN-1:0] cand_pw,
    output logic [4:0]           cand_len,
    output logic [COUNT_W-1:0]   cand_count,
    output logic                 busy,
    output logic                 exhausted
);
    localparam logic [4:0]   LEN_MAX     = 5'(MAX_LEN);
    // Empty password: only the 0x80 pad in byte 0, bit length zero.
    localparam logic [511:0] EMPTY_BLOCK = 512'h80;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state;

    // UTF-16LE chars, 0x80 pad at byte 2L, 16*L bit length little-endian at byte 56.
    function automatic logic [511:0] make_block(input logic [8*MAX_LEN-1:0] pw,
                                                input logic [4:0]           len);
        logic [511:0] blk;
        logic [8:0]   pad_bit;
        blk = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < 32'(len)) blk[16*i +: 8] = pw[8*i +: 8];
        end
        pad_bit              = {len, 4'b0000};
        blk[pad_bit +: 8]    = 8'h80;
        blk[448 +: 64]       = 64'({len, 4'b0000});
        return blk;
    endfunction

    logic [8*MAX_LEN-1:0] nxt_pw;
    logic [4:0]           nxt_len;
    logic                 nxt_end;
    logic                 carry;
    int unsigned          idx;

    // Odometer successor of the current candidate; nxt_end flags carry out of the longest length.
    always_comb begin
        nxt_pw  = cand_pw;
        nxt_len = cand_len;
        nxt_end = 1'b0;
        carry   = 1'b1;
        idx     = 0;
        if (cand_len == 5'd0) begin
            nxt_pw       = '0;
            nxt_pw[7:0]  = MIN_CHAR;
            nxt_len      = 5'd1;
        end else begin
            for (int unsigned j = 0; j < MAX_LEN; j++) begin
                idx = MAX_LEN - 1 - j;
                if (idx < 32'(cand_len) && carry) begin
                    if (cand_pw[8*idx +: 8] == MAX_CHAR) begin
                        nxt_pw[8*idx +: 8] = MIN_CHAR;
                    end else begin
                        nxt_pw[8*idx +: 8] = cand_pw[8*idx +: 8] + 8'd1;
                        carry              = 1'b0;
                    end
                end
            end
            if (carry) begin
                if (cand_len == LEN_MAX) begin
                    nxt_end = 1'b1;
                end else begin
                    nxt_len = cand_len + 5'd1;
                    for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        nxt_pw[8*i +: 8] = (i < 32'(nxt_len)) ? MIN_CHAR : 8'h00;
                    end
                end
            end
        end
    end

    logic                 go;
    logic [8*MAX_LEN-1:0] load_pw;
    logic [4:0]           load_len;

`ifdef NTCAND_RESUME_EN
    // Entry point for RUN: sanitised resume password when loading, else the empty password.
    always_comb begin
        go       = start | resume_load;
        load_pw  = '0;
        load_len = '0;
        if (resume_load) begin
            load_len = (resume_len > LEN_MAX) ? LEN_MAX : resume_len;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (i < 32'(load_len)) begin
                    if (resume_pw[8*i +: 8] < MIN_CHAR || resume_pw[8*i +: 8] > MAX_CHAR)
                        load_pw[8*i +: 8] = MIN_CHAR;
                    else
                        load_pw[8*i +: 8] = resume_pw[8*i +: 8];
                end
            end
        end
    end
`else
    // Entry point for RUN: always the empty password.
    always_comb begin
        go       = start;
        load_pw  = '0;
        load_len = '0;
    end
`endif

    // Control FSM with registered stream outputs; the block is registered with the candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            exhausted  <= 1'b0;
            cand_len   <= '0;
            cand_pw    <= '0;
            cand_count <= '0;
            md4_block  <= EMPTY_BLOCK;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state      <= S_RUN;
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                        exhausted  <= 1'b0;
                        cand_count <= '0;
                        cand_pw    <= load_pw;
                        cand_len   <= load_len;
                        md4_block  <= make_block(load_pw, load_len);
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (out_valid && out_ready) begin
                        if (cand_count != '1) cand_count <= cand_count + 1'b1;
                        if (nxt_end) begin
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            exhausted <= 1'b1;
                        end else begin
                            cand_pw   <= nxt_pw;
                            cand_len  <= nxt_len;
                            md4_block <= make_block(nxt_pw, nxt_len);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
